uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Next-generation UART transmitter for the UART subsystem, running on a single system clock instead of a dedicated baud clock.
- An internal programmable baud divider paces each bit.
- A parametrised input FIFO buffers bytes.
- Frame format is configurable at run time: data width, parity, 1 or 2 stop bits.
- Sits between the register/ALU side and the serial line; accepts words through a valid/ready handshake and transmits frames back-to-back without idle gaps.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9).
- FIFO_DEPTH, 4, FIFO entries (power of two, >=2).
- DIV_WIDTH, 16, width of BAUD_DIV.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WIDTH  parallel word to transmit.
- DATA_VALID  in  1  write request.
- READY  out  1  FIFO not full; a write is accepted on an edge where DATA_VALID && READY.
- BAUD_DIV  in  DIV_WIDTH  bit period = BAUD_DIV+1 CLK cycles.
- PAR_EN  in  1  parity bit enable.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  0 = one stop bit, 1 = two stop bits.
- TX_OUT  out  1  serial line, idle high.
- BUSY  out  1  frame in progress.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH+1)  occupied entries.

Behaviour:
- Reset (async, RST=0):
  - TX_OUT=1, BUSY=0, READY=1, FIFO_COUNT=0.
  - FIFO pointers cleared; FSM to IDLE.
  - Takes effect immediately, including mid-frame; the partial frame is discarded.
- FIFO:
  - A write is rejected when full, even if a pop occurs on the same edge.
  - Simultaneous push and pop when not full: FIFO_COUNT unchanged.
  - A pushed word is visible to the FSM on the following edge.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1, BUSY=0. If the FIFO is non-empty at an edge: pop into the shift register, go to START, TX_OUT=0 and BUSY=1 registered on that same edge. Latency: write accepted at edge k gives TX_OUT low after edge k+1.
  - Config capture: BAUD_DIV, PAR_EN, PAR_TYP and STOP2 are sampled at the pop edge and held for the whole frame. Mid-frame changes have no effect.
  - Bit timing: each bit is held exactly BAUD_DIV+1 cycles by a down-counter reloaded at each bit boundary. BAUD_DIV=0 gives 1 cycle per bit.
  - START -> DATA: DATA_WIDTH bits, LSB first.
  - DATA -> PARITY if PAR_EN, else STOP.
  - PARITY: bit = XOR of data bits, inverted when PAR_TYP=1.
  - STOP: 1 or 2 stop bits (high).
  - End of the last stop bit: if the FIFO is non-empty, pop and go directly to START on the same edge, with BUSY staying high. Otherwise go to IDLE with BUSY=0.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × (BAUD_DIV+1) cycles.
- All outputs are registered except READY and FIFO_COUNT, which are decoded from the registered FIFO count.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input port SEND_BREAK (1 bit).
  - In IDLE with SEND_BREAK=1, enter a BREAK state: TX_OUT=0 and BUSY=1 while SEND_BREAK stays high. FIFO pops are suspended.
  - On deassertion, return to IDLE with TX_OUT=1 for at least one full bit period (BAUD_DIV+1 cycles) before any new START.
  - SEND_BREAK during a frame is ignored until that frame ends, and takes priority over a pending pop.
- Undefined: no SEND_BREAK port, no BREAK state; behaviour as above.

Decomposition:
- Shared package uart_pkg:
  - state enum typedef (IDLE, START, DATA, PARITY, STOP, BREAK).
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1.
  - function for frame-bit count.
- One natural sub-module: uart_sync_fifo, a parametrised single-clock FIFO with push/pop/full/empty/count.
- Baud counter and FSM stay in uart_tx_fifo.

Test Plan:
- Reset: apply RST=0 mid-idle -> TX_OUT=1, BUSY=0, READY=1, FIFO_COUNT=0.
- Basic frame: DATA_WIDTH=8, BAUD_DIV=3, PAR_EN=0, STOP2=0; write 0xA5 -> TX_OUT per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. BUSY high exactly 40 cycles; TX_OUT falls one edge after acceptance.
- Parity/stop: 0x0F, PAR_EN=1, STOP2=1:
  - PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1.
  - Frame is 12 bits = 48 cycles.
  - Changing PAR_TYP mid-frame does not alter the current frame.
- Full/back-to-back: FIFO_DEPTH=4; write 6 words on consecutive edges.
  - FIFO_COUNT reaches 4 and READY drops; the 6th write is held.
  - The 6th word is accepted after the next pop.
  - All 6 frames are sent in order with no idle cycle between the stop bit and the next start bit; BUSY never drops.
- Reset mid-frame: assert RST during data bit 3 -> TX_OUT=1 asynchronously, FIFO_COUNT=0. After release, TX_OUT stays high and no frame is sent.
- Break (UART_TX_BREAK_EN): SEND_BREAK high 20 cycles while idle with BAUD_DIV=3 and one word queued -> TX_OUT low 20 cycles, then high ≥4 cycles, then the queued frame starts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the single-clock UART transmitter.
//   uart_state_e : transmitter FSM states (BREAK is only reachable when the
//                  design is built with UART_TX_BREAK_EN defined)
//   PAR_EVEN/ODD : encodings of the PAR_TYP input
//   frame_bits() : number of bit periods in one frame for a given format
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int unsigned frame_bits(input int unsigned data_width,
                                               input logic        par_en,
                                               input logic        stop2);
        return 32'd2 + data_width + 32'(par_en) + 32'(stop2);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO buffering words for the UART transmitter.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, wdata    : write request and word (ignored when full)
//   pop            : read request (ignored when empty); rdata shows the head
//   full, empty    : status flags decoded from the registered count
//   count          : occupied entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // Fullness is judged before any same-edge pop, so a write at full is
    // always rejected.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO and internal baud divider, one clock.
// Ports:
//   CLK, RST            : system clock, asynchronous active-low reset
//   P_DATA, DATA_VALID  : word to send, accepted when DATA_VALID && READY
//   READY               : FIFO not full
//   BAUD_DIV            : bit period is BAUD_DIV+1 clocks
//   PAR_EN, PAR_TYP     : parity enable, 0 = even / 1 = odd
//   STOP2               : two stop bits when 1
//   SEND_BREAK          : hold line low while idle (UART_TX_BREAK_EN only)
//   TX_OUT, BUSY        : serial line (idle high), frame in progress
//   FIFO_COUNT          : occupied FIFO entries
// Build option: define UART_TX_BREAK_EN to add SEND_BREAK and the BREAK state.
// Frame format is captured when a word leaves the FIFO and held to its end.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [DATA_WIDTH-1:0]             P_DATA,
    input  logic                              DATA_VALID,
    output logic                              READY,
    input  logic [DIV_WIDTH-1:0]              BAUD_DIV,
    input  logic                              PAR_EN,
    input  logic                              PAR_TYP,
    input  logic                              STOP2,
`ifdef UART_TX_BREAK_EN
    input  logic                              SEND_BREAK,
`endif
    output logic                              TX_OUT,
    output logic                              BUSY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_COUNT
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  par_en_q, par_en_d;
    logic                  parity_q, parity_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  guard_q, guard_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  start_frame;
    logic                  bit_done;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (DATA_VALID),
        .wdata (P_DATA),
        .pop   (start_frame),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (FIFO_COUNT)
    );

    assign bit_done = (baud_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        baud_cnt_d  = bit_done ? div_q : baud_cnt_q - DIV_WIDTH'(1);
        div_d       = div_q;
        par_en_d    = par_en_q;
        parity_d    = parity_q;
        stop2_d     = stop2_q;
        stop_cnt_d  = stop_cnt_q;
        guard_d     = guard_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                baud_cnt_d = baud_cnt_q;
`ifdef UART_TX_BREAK_EN
                if (SEND_BREAK) begin
                    state_d = BREAK;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    guard_d = 1'b0;
                end else
`endif
                // guard_q holds off the next start for one bit period of
                // high line after a break.
                if (guard_q && !bit_done) begin
                    baud_cnt_d = baud_cnt_q - DIV_WIDTH'(1);
                end else begin
                    guard_d     = 1'b0;
                    start_frame = !fifo_empty;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    tx_d      = shreg_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        stop_cnt_d = 1'b0;
                        state_d    = par_en_q ? PARITY : STOP;
                        tx_d       = par_en_q ? parity_q : 1'b1;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else
`ifdef UART_TX_BREAK_EN
                    if (SEND_BREAK) begin
                        state_d = BREAK;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end else
`endif
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                baud_cnt_d = baud_cnt_q;
                if (!SEND_BREAK) begin
                    state_d    = IDLE;
                    tx_d       = 1'b1;
                    busy_d     = 1'b0;
                    guard_d    = 1'b1;
                    baud_cnt_d = BAUD_DIV;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Popping a word also latches the frame format for its duration.
        if (start_frame) begin
            state_d    = START;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            shreg_d    = fifo_rdata;
            div_d      = BAUD_DIV;
            baud_cnt_d = BAUD_DIV;
            par_en_d   = PAR_EN;
            stop2_d    = STOP2;
            stop_cnt_d = 1'b0;
            parity_d   = (^fifo_rdata) ^ (PAR_TYP == PAR_ODD);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            parity_q   <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            guard_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            parity_q   <= parity_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            guard_q    <= guard_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;
    assign READY  = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (DATA_WIDTH=8, FIFO_DEPTH=4).
// A queue-based reference model predicts the line level, BUSY, FIFO_COUNT
// and READY after every clock edge; directed tables add fixed expectations.
module tb_uart_tx_fifo;

    logic        CLK;
    logic        RST;
    logic [7:0]  P_DATA;
    logic        DATA_VALID;
    logic        READY;
    logic [15:0] BAUD_DIV;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        STOP2;
    logic        TX_OUT;
    logic        BUSY;
    logic [2:0]  FIFO_COUNT;
`ifdef UART_TX_BREAK_EN
    logic        SEND_BREAK;
`endif

    int checks = 0;
    int errors = 0;
    bit model_en = 1'b1;

    // Expected line level for each cycle still to come, and queued words.
    logic       line_q[$];
    logic [7:0] fifo_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  div;
        logic        pe;
        logic        pt;
        logic        s2;
        logic        flip;
        logic [11:0] bits;   // line sequence, first bit sent is leftmost
        int          nbits;
    } vec_t;

    vec_t tbl[6];

    uart_tx_fifo #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .READY      (READY),
        .BAUD_DIV   (BAUD_DIV),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
`ifdef UART_TX_BREAK_EN
        .SEND_BREAK (SEND_BREAK),
`endif
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY),
        .FIFO_COUNT (FIFO_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic append_frame(input logic [7:0] d, input int unsigned div,
                                input logic pe, input logic pt, input logic s2);
        logic seq[$];
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) seq.push_back(d[i]);
        if (pe) seq.push_back((^d) ^ pt);
        seq.push_back(1'b1);
        if (s2) seq.push_back(1'b1);
        foreach (seq[i]) begin
            repeat (div + 1) line_q.push_back(seq[i]);
        end
    endtask

    task automatic check_model();
        logic [5:0] exp;
        exp[5]   = (line_q.size() == 0) ? 1'b1 : line_q[0];
        exp[4]   = (line_q.size() != 0);
        exp[3:1] = 3'(fifo_q.size());
        exp[0]   = (fifo_q.size() < 4);
        check("line_model{tx,busy,count,ready}",
              32'({TX_OUT, BUSY, FIFO_COUNT, READY}), 32'(exp));
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare #1 later.
    task automatic step();
        int pre;
        @(posedge CLK);
        if (!RST) begin
            line_q.delete();
            fifo_q.delete();
        end else if (model_en) begin
            pre = fifo_q.size();
            if (line_q.size() != 0) void'(line_q.pop_front());
            if (line_q.size() == 0 && fifo_q.size() != 0)
                append_frame(fifo_q.pop_front(), 32'(BAUD_DIV), PAR_EN, PAR_TYP, STOP2);
            if (DATA_VALID && pre < 4) fifo_q.push_back(P_DATA);
        end
        #1;
        if (model_en) check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"},    32'(TX_OUT), 32'd1);
        check({tag, "_busy"},  32'(BUSY), 32'd0);
        check({tag, "_ready"}, 32'(READY), 32'd1);
        check({tag, "_count"}, 32'(FIFO_COUNT), 32'd0);
    endtask

    int   per, cyc, t, idx, held, busy_cyc, low_cnt, hi_cnt, maxc;
    bit   started, full_seen;
    logic rdy;
    logic [7:0] words[6];

    initial begin
        tbl[0] = '{8'hA5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 12'b0101001011,   10};
        tbl[1] = '{8'h0F, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 12'b011110000011, 12};
        tbl[2] = '{8'h0F, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 12'b011110000111, 12};
        tbl[3] = '{8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'b00000000011,  11};
        tbl[4] = '{8'hFF, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 12'b011111111011, 12};
        tbl[5] = '{8'h3C, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 12'b00011110011,  11};
        words  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        RST = 1'b1; P_DATA = '0; DATA_VALID = 1'b0; BAUD_DIV = 16'd3;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
`ifdef UART_TX_BREAK_EN
        SEND_BREAK = 1'b0;
`endif
        #2 RST = 1'b0;
        #1 check_reset_outputs("reset_initial");
        step(); step();
        RST = 1'b1;
        repeat (3) step();

        // Reset while idle.
        #2 RST = 1'b0;
        #1 check_reset_outputs("reset_idle");
        step();
        RST = 1'b1;
        step();

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            per = int'(tbl[v].div) + 1;
            BAUD_DIV = 16'(tbl[v].div);
            PAR_EN = tbl[v].pe; PAR_TYP = tbl[v].pt; STOP2 = tbl[v].s2;
            P_DATA = tbl[v].data; DATA_VALID = 1'b1;
            step();
            check("accept_edge_tx_still_high", 32'(TX_OUT), 32'd1);
            check("accept_edge_count", 32'(FIFO_COUNT), 32'd1);
            DATA_VALID = 1'b0;
            cyc = tbl[v].nbits * per;
            for (int c = 0; c < cyc; c++) begin
                step();
                if (tbl[v].flip && c == 10) begin
                    PAR_TYP = ~PAR_TYP; BAUD_DIV = 16'd0; STOP2 = 1'b0; PAR_EN = 1'b0;
                end
                check($sformatf("vec%0d_bit%0d", v, c / per),
                      32'({BUSY, TX_OUT}),
                      32'({1'b1, tbl[v].bits[tbl[v].nbits - 1 - c / per]}));
            end
            step();
            check($sformatf("vec%0d_end_idle", v), 32'({BUSY, TX_OUT}), 32'b01);
        end

        // Six writes on consecutive edges into a four-deep FIFO.
        BAUD_DIV = 16'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        idx = 0; held = 0; busy_cyc = 0; maxc = 0; started = 0; full_seen = 0; t = 0;
        P_DATA = words[0]; DATA_VALID = 1'b1;
        while (t < 400) begin
            rdy = READY;
            step();
            t++;
            if (DATA_VALID && rdy) begin
                idx++;
                if (idx < 6) P_DATA = words[idx];
                else DATA_VALID = 1'b0;
            end else if (DATA_VALID && idx == 5) begin
                held++;
            end
            if (int'(FIFO_COUNT) > maxc) maxc = int'(FIFO_COUNT);
            if (FIFO_COUNT == 3'd4 && !READY) full_seen = 1'b1;
            if (BUSY) begin
                started = 1'b1;
                busy_cyc++;
            end else if (started) begin
                break;
            end
        end
        DATA_VALID = 1'b0;
        check("burst_all_accepted", 32'(idx), 32'd6);
        check("burst_max_count", 32'(maxc), 32'd4);
        check("burst_ready_low_when_full", 32'(full_seen), 32'd1);
        check("burst_sixth_word_held", 32'(held > 0), 32'd1);
        check("burst_busy_continuous_cycles", 32'(busy_cyc), 32'd60);

        // Reset during data bit 3 of a frame.
        BAUD_DIV = 16'd3;
        P_DATA = 8'h00; DATA_VALID = 1'b1;
        step();
        P_DATA = 8'h5A;
        step();
        DATA_VALID = 1'b0;
        repeat (17) step();
        check("midframe_tx_low_before_reset", 32'(TX_OUT), 32'd0);
        check("midframe_count_before_reset", 32'(FIFO_COUNT), 32'd1);
        #2 RST = 1'b0;
        #1 check_reset_outputs("reset_midframe");
        step(); step();
        RST = 1'b1;
        low_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (!TX_OUT) low_cnt++;
        end
        check("after_reset_line_quiet", 32'(low_cnt), 32'd0);

        // Randomised traffic with format changes at arbitrary times.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                BAUD_DIV = 16'($urandom_range(0, 3));
                PAR_EN   = 1'($urandom_range(0, 1));
                PAR_TYP  = 1'($urandom_range(0, 1));
                STOP2    = 1'($urandom_range(0, 1));
            end
            if ((n % 600) < 300) DATA_VALID = ($urandom_range(0, 3) != 0);
            else DATA_VALID = ($urandom_range(0, 15) == 0);
            P_DATA = 8'($urandom_range(0, 255));
            step();
        end
        DATA_VALID = 1'b0;
        t = 0;
        while ((BUSY || FIFO_COUNT != 3'd0) && t < 2000) begin
            step();
            t++;
        end
        check("random_drained", 32'({BUSY, FIFO_COUNT}), 32'd0);

`ifdef UART_TX_BREAK_EN
        // Break while idle with one word queued.
        model_en = 1'b0;
        BAUD_DIV = 16'd3; PAR_EN = 1'b0; STOP2 = 1'b0;
        SEND_BREAK = 1'b1; P_DATA = 8'h55; DATA_VALID = 1'b1;
        low_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            DATA_VALID = 1'b0;
            if (!TX_OUT && BUSY) low_cnt++;
        end
        check("break_low_cycles", 32'(low_cnt), 32'd20);
        check("break_word_queued", 32'(FIFO_COUNT), 32'd1);
        SEND_BREAK = 1'b0;
        hi_cnt = 0; t = 0;
        step();
        while (TX_OUT && t < 40) begin
            hi_cnt++;
            step();
            t++;
        end
        check("break_recovery_high_at_least_bit", 32'(hi_cnt >= 4), 32'd1);
        check("break_then_frame_starts", 32'({BUSY, TX_OUT}), 32'b10);
        t = 0;
        while (BUSY && t < 100) begin
            step();
            t++;
        end
        check("break_frame_finished", 32'(BUSY), 32'd0);
        line_q.delete();
        fifo_q.delete();
        model_en = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
